antares_gpr_dbg_port: RTL

Debug access engine for the Antares 32×32-bit general purpose register file. On a host command it halts the core, then either streams a contiguous range of GPRs out (dump) or writes a stream of host words into a range (load). It drives the register file's read-address/write ports from the debug side and releases the core when the operation finishes. It sits between the debug transport and the GPR file, and is muxed onto the file's ports while the core is halted.

---
 rtl/antares_gpr_dbg_port.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/antares_gpr_dbg_port.sv
// Debug access engine: halts the core, then dumps or loads a contiguous GPR range over valid/ready streams.
// Optional feature macro ANTARES_GPR_DBG_CHECKSUM_EN appends a running-XOR checksum word to every transfer.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// HALT  | halt_req high, waiting for halt_ack or the timeout
// DUMP  | streaming GPR[idx] on out_*
// LOAD  | writing in_data into GPR[idx]
// CSUM  | checksum word out (dump) or in (load), checksum build only
// DONE  | core released, done pulse
module antares_gpr_dbg_port #(
  parameter int unsigned HALT_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [4:0]  cmd_first_i,
  input  logic [4:0]  cmd_last_i,
  output logic        halt_req_o,
  input  logic        halt_ack_i,
  output logic [4:0]  gpr_ra_o,
  input  logic [31:0] gpr_rd_i,
  output logic [4:0]  gpr_wa_o,
  output logic [31:0] gpr_wd_o,
  output logic        gpr_we_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic        out_last_o,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_DUMP,
    S_LOAD,
`ifdef ANTARES_GPR_DBG_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_e;

  localparam logic [15:0] TMO_INIT = 16'(HALT_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  last_q, last_d;
  logic [15:0] tmo_q, tmo_d;
  logic [31:0] out_data_q, out_data_d;
  logic        err_q, err_d;
`ifdef ANTARES_GPR_DBG_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;
`endif

  logic        at_last;
  logic [31:0] rd_word;

  assign at_last  = (idx_q == last_q);
  // In DUMP the read port looks one word ahead so the next word loads on the handshake edge.
  assign gpr_ra_o = (state_q == S_DUMP) ? idx_q + 5'd1 : idx_q;
  assign rd_word  = (gpr_ra_o == 5'd0) ? 32'd0 : gpr_rd_i;

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    idx_d      = idx_q;
    last_d     = last_q;
    tmo_d      = tmo_q;
    out_data_d = out_data_q;
    err_d      = 1'b0;
`ifdef ANTARES_GPR_DBG_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_first_i > cmd_last_i) begin
            err_d = 1'b1;
          end else begin
            write_d = cmd_write_i;
            idx_d   = cmd_first_i;
            last_d  = cmd_last_i;
            tmo_d   = TMO_INIT;
            state_d = S_HALT;
`ifdef ANTARES_GPR_DBG_CHECKSUM_EN
            csum_d  = 32'd0;
`endif
          end
        end
      end
      S_HALT: begin
        if (halt_ack_i) begin
          state_d = write_q ? S_LOAD : S_DUMP;
          if (!write_q) out_data_d = rd_word;
        end else if (tmo_q == 16'd0) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q - 16'd1;
        end
      end
      S_DUMP: begin
        if (out_ready_i) begin
`ifdef ANTARES_GPR_DBG_CHECKSUM_EN
          csum_d = csum_q ^ out_data_q;
`endif
          if (at_last) begin
`ifdef ANTARES_GPR_DBG_CHECKSUM_EN
            state_d    = S_CSUM;
            out_data_d = csum_q ^ out_data_q;
`else
            state_d    = S_DONE;
`endif
          end else begin
            idx_d      = idx_q + 5'd1;
            out_data_d = rd_word;
          end
        end
      end
      S_LOAD: begin
        if (in_valid_i) begin
`ifdef ANTARES_GPR_DBG_CHECKSUM_EN
          csum_d = csum_q ^ in_data_i;
`endif
          if (at_last) begin
`ifdef ANTARES_GPR_DBG_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
`ifdef ANTARES_GPR_DBG_CHECKSUM_EN
      S_CSUM: begin
        if (write_q) begin
          if (in_valid_i) begin
            err_d   = (in_data_i != csum_q);
            state_d = S_DONE;
          end
        end else if (out_ready_i) begin
          state_d = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      idx_q      <= 5'd0;
      last_q     <= 5'd0;
      tmo_q      <= 16'd0;
      out_data_q <= 32'd0;
      err_q      <= 1'b0;
`ifdef ANTARES_GPR_DBG_CHECKSUM_EN
      csum_q     <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      tmo_q      <= tmo_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
`ifdef ANTARES_GPR_DBG_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign err_o       = err_q;
  assign out_data_o  = out_data_q;

`ifdef ANTARES_GPR_DBG_CHECKSUM_EN
  assign halt_req_o  = (state_q == S_HALT) || (state_q == S_DUMP) ||
                       (state_q == S_LOAD) || (state_q == S_CSUM);
  assign out_valid_o = (state_q == S_DUMP) || ((state_q == S_CSUM) && !write_q);
  assign out_last_o  = (state_q == S_CSUM) && !write_q;
  assign in_ready_o  = (state_q == S_LOAD) || ((state_q == S_CSUM) && write_q);
`else
  assign halt_req_o  = (state_q == S_HALT) || (state_q == S_DUMP) || (state_q == S_LOAD);
  assign out_valid_o = (state_q == S_DUMP);
  assign out_last_o  = (state_q == S_DUMP) && at_last;
  assign in_ready_o  = (state_q == S_LOAD);
`endif

  // r0 is hard-wired, so its load word is consumed without a write.
  assign gpr_we_o = (state_q == S_LOAD) && in_valid_i && (idx_q != 5'd0);
  assign gpr_wa_o = (state_q == S_LOAD) ? idx_q : 5'd0;
  assign gpr_wd_o = (state_q == S_LOAD) ? in_data_i : 32'd0;

endmodule
